// File: rtl/shift_counter_pkg.sv
// -----------------------------------------------------------------------------
// shift_counter_pkg
//  Shared constants and helpers for the shift-register counter family.
//  Contents:
//   MODE_RING / MODE_JOHNSON  mode select encodings
//   DIR_UP / DIR_DN           shift direction encodings (toward MSB / toward LSB)
//   period(width, mode)       number of shifts in one full sequence
// -----------------------------------------------------------------------------
package shift_counter_pkg;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   // A ring of N bits repeats after N shifts; a twisted ring needs 2N.
   function automatic int unsigned period(input int unsigned width, input logic mode);
      return (mode == MODE_JOHNSON) ? (2 * width) : width;
   endfunction

endpackage

// File: rtl/shift_counter_legal_chk.sv
// -----------------------------------------------------------------------------
// shift_counter_legal_chk
//  Combinational legality check of a shift-counter state for a given mode.
//  Ring mode: legal states are exactly one-hot.
//  Johnson mode: legal states have at most one bit transition between adjacent
//  positions state[0..WIDTH-1], not counting the wrap-around pair.
//  Ports:
//   state_i    in  WIDTH  state to check
//   mode_i     in  1      MODE_RING / MODE_JOHNSON
//   illegal_o  out 1      1 when state_i is not a legal state for mode_i
// -----------------------------------------------------------------------------
module shift_counter_legal_chk
   import shift_counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] state_i,
   input  logic             mode_i,
   output logic             illegal_o
);

   logic [WIDTH-2:0] edges;
   logic             one_hot;
   logic             multi_edge;

   // Bit k set where state[k] differs from state[k+1].
   assign edges = state_i[WIDTH-1:1] ^ state_i[WIDTH-2:0];

   // x & (x-1) clears the lowest set bit, so a zero result means at most one bit set.
   assign one_hot    = (state_i != '0) && ((state_i & (state_i - WIDTH'(1))) == '0);
   assign multi_edge = ((edges & (edges - (WIDTH-1)'(1))) != '0);

   assign illegal_o = (mode_i == MODE_RING) ? !one_hot : multi_edge;

endmodule

// File: rtl/shift_counter_param.sv
// -----------------------------------------------------------------------------
// shift_counter_param
//  Parametrised shift-register counter with runtime ring / Johnson selection,
//  direction control, enable, synchronous load, a registered period-wrap pulse
//  and a combinational illegal-state flag.
//
//  Build option: SHIFT_COUNTER_SELF_CORRECT_EN
//   defined   - an enabled shift from an illegal state loads the mode start state
//               (ring: 1, Johnson: 0), clears the step count and suppresses wrap.
//   undefined - illegal is status only; illegal patterns keep shifting.
//
//  Parameters:
//   WIDTH      state width, 2..32
//   RESET_VAL  state forced by rst (not checked for legality)
//  Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      asynchronous active-high reset
//   en         in  1      advance one step
//   mode       in  1      0 ring, 1 Johnson
//   dir        in  1      0 toward MSB, 1 toward LSB
//   load       in  1      synchronous load of load_val (wins over en)
//   load_val   in  WIDTH  value to load
//   out        out WIDTH  registered counter state
//   wrap       out 1      registered one-cycle pulse after a full period
//   illegal    out 1      out is not a legal state for the current mode
// -----------------------------------------------------------------------------
module shift_counter_param
   import shift_counter_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             wrap,
   output logic             illegal
);

   localparam int CNT_W = $clog2(2 * WIDTH);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("shift_counter_param: WIDTH must be in 2..32");
   end

   logic [WIDTH-1:0] state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic             mode_q;

   logic [WIDTH-1:0] shifted;
   logic [CNT_W-1:0] last_step;
   logic             mode_chg;
   logic             fb_up;
   logic             fb_dn;
   logic             illegal_now;

   shift_counter_legal_chk #(
      .WIDTH (WIDTH)
   ) u_legal_chk (
      .state_i   (state_q),
      .mode_i    (mode),
      .illegal_o (illegal_now)
   );

   // The live mode input selects the shift rule and period, so a mode change
   // takes effect on the same edge it is first seen.
   assign mode_chg  = (mode != mode_q);
   assign last_step = CNT_W'(period(WIDTH, mode) - 1);

   // Johnson feedback is the inverted bit leaving the register.
   assign fb_up   = state_q[WIDTH-1] ^ (mode == MODE_JOHNSON);
   assign fb_dn   = state_q[0]       ^ (mode == MODE_JOHNSON);
   assign shifted = (dir == DIR_UP) ? {state_q[WIDTH-2:0], fb_up}
                                    : {fb_dn, state_q[WIDTH-1:1]};

`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
   logic [WIDTH-1:0] start_state;
   assign start_state = (mode == MODE_RING) ? WIDTH'(1) : '0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      if (load) begin
         state_d = load_val;
         cnt_d   = '0;
      end else if (en) begin
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
         if (illegal_now) begin
            state_d = start_state;
            cnt_d   = '0;
         end else begin
`endif
            state_d = shifted;
            // A shift on the same edge as a mode change starts a fresh period.
            if (mode_chg) begin
               cnt_d = '0;
            end else if (cnt_q == last_step) begin
               cnt_d  = '0;
               wrap_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
         end
`endif
      end else if (mode_chg) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RESET_VAL;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         mode_q  <= MODE_RING;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         mode_q  <= mode;
      end
   end

   assign out     = state_q;
   assign wrap    = wrap_q;
   assign illegal = illegal_now;

endmodule

// File: tb/tb_shift_counter_param.sv
module tb_shift_counter_param;

`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
   localparam bit SELF_CORRECT = 1'b1;
`else
   localparam bit SELF_CORRECT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       mode;
   logic       dir;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] out_w;
   logic       wrap;
   logic       illegal;

   int tests = 0;
   int fails = 0;

   // reference model: state, shifts since period start, wrap, registered mode
   logic [3:0] m_out;
   int         m_steps;
   logic       m_wrap;
   logic       m_mode_q;

   logic [3:0] t1_exp [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                              4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] t2_exp [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                              4'b1110, 4'b1100, 4'b1000, 4'b0000};
   logic [3:0] t3_exp [5] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111};

   shift_counter_param #(
      .WIDTH     (4),
      .RESET_VAL (4'b0001)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .out      (out_w),
      .wrap     (wrap),
      .illegal  (illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic m_illegal(input logic [3:0] s, input logic md);
      int n;
      if (md == 1'b0) return ($countones(s) != 1);
      n = 0;
      for (int i = 0; i < 3; i++) if (s[i] != s[i+1]) n++;
      return (n > 1);
   endfunction

   // Next state by arithmetic: multiply/divide by two, then fill the vacated end.
   function automatic logic [3:0] m_next(input logic [3:0] s, input logic md, input logic dr);
      int v, msb, lsb, fill;
      v   = int'(s);
      msb = v / 8;
      lsb = v % 2;
      if (dr == 1'b0) begin
         fill = md ? (1 - msb) : msb;
         return 4'(((v * 2) % 16) + fill);
      end
      fill = md ? (1 - lsb) : lsb;
      return 4'((v / 2) + 8 * fill);
   endfunction

   task automatic model_reset();
      m_out    = 4'b0001;
      m_steps  = 0;
      m_wrap   = 1'b0;
      m_mode_q = 1'b0;
   endtask

   task automatic model_edge();
      int p;
      p      = mode ? 8 : 4;
      m_wrap = 1'b0;
      if (load) begin
         m_out   = load_val;
         m_steps = 0;
      end else if (en) begin
         if (SELF_CORRECT && m_illegal(m_out, mode)) begin
            m_out   = mode ? 4'b0000 : 4'b0001;
            m_steps = 0;
         end else begin
            m_out = m_next(m_out, mode, dir);
            if (mode != m_mode_q) m_steps = 0;
            else begin
               m_steps++;
               if (m_steps == p) begin
                  m_steps = 0;
                  m_wrap  = 1'b1;
               end
            end
         end
      end else if (mode != m_mode_q) begin
         m_steps = 0;
      end
      m_mode_q = mode;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_edge();
      check("model_out", 32'(out_w), 32'(m_out));
      check("model_wrap", 32'(wrap), 32'(m_wrap));
      check("model_illegal", 32'(illegal), 32'(m_illegal(m_out, mode)));
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'b0000;
      model_reset();

      // reset state
      #2 rst = 1'b1;
      #1;
      check("rst_out", 32'(out_w), 32'h1);
      check("rst_wrap", 32'(wrap), 32'h0);
      check("rst_illegal", 32'(illegal), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // test 1: ring walk
      en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("t1_out", 32'(out_w), 32'(t1_exp[k]));
         check("t1_wrap", 32'(wrap), 32'((k == 3) || (k == 7)));
      end

      // test 2: Johnson walk
      en = 1'b0; load = 1'b1; load_val = 4'b0000; mode = 1'b1;
      tick();
      load = 1'b0; en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("t2_out", 32'(out_w), 32'(t2_exp[k]));
         check("t2_wrap", 32'(wrap), 32'(k == 7));
         check("t2_illegal", 32'(illegal), 32'h0);
      end

      // test 3: direction
      en = 1'b0; load = 1'b1; load_val = 4'b0000; dir = 1'b1;
      tick();
      load = 1'b0; en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t3_johnson_dn", 32'(out_w), 32'(t3_exp[k]));
      end
      en = 1'b0; mode = 1'b0; load = 1'b1; load_val = 4'b0001;
      tick();
      load = 1'b0; en = 1'b1;
      tick();
      check("t3_ring_dn0", 32'(out_w), 32'b1000);
      tick();
      check("t3_ring_dn1", 32'(out_w), 32'b0100);
      dir = 1'b0;

      // test 4: load beats en, then async reset mid-cycle right after a wrap
      load = 1'b1; en = 1'b1; load_val = 4'b0100;
      tick();
      check("t4_load_pri", 32'(out_w), 32'b0100);
      check("t4_load_wrap", 32'(wrap), 32'h0);
      load = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check("t4_pre_rst_out", 32'(out_w), 32'b0100);
      check("t4_pre_rst_wrap", 32'(wrap), 32'h1);
      #3 rst = 1'b1;
      model_reset();
      #1;
      check("t4_rst_out", 32'(out_w), 32'b0001);
      check("t4_rst_wrap", 32'(wrap), 32'h0);
      #2 rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t4_post_rst_wrap", 32'(wrap), 32'(k == 3));
      end

      // test 5: illegal detection
      en = 1'b0; load = 1'b1; load_val = 4'b0110;
      tick();
      check("t5_illegal", 32'(illegal), 32'h1);
      load = 1'b0; en = 1'b1;
      tick();
      check("t5_next_out", 32'(out_w), SELF_CORRECT ? 32'b0001 : 32'b1100);
      check("t5_next_illegal", 32'(illegal), SELF_CORRECT ? 32'h0 : 32'h1);

      // test 6: mode switch holds state and restarts the period
      en = 1'b0; load = 1'b1; load_val = 4'b0001;
      tick();
      load = 1'b0; en = 1'b1;
      tick();
      tick();
      check("t6_ring_at", 32'(out_w), 32'b0100);
      en = 1'b0; mode = 1'b1;
      tick();
      check("t6_hold", 32'(out_w), 32'b0100);
      check("t6_illegal_j", 32'(illegal), 32'h1);
      en = 1'b1;
      tick();
      check("t6_step_out", 32'(out_w), SELF_CORRECT ? 32'b0000 : 32'b1001);
      check("t6_step_illegal", 32'(illegal), SELF_CORRECT ? 32'h0 : 32'h1);
      for (int k = 0; k < 9; k++) tick();

      // randomized traffic against the model
      en = 1'b0; load = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      check("rnd_rst_out", 32'(out_w), 32'b0001);
      rst = 1'b0;
      mode = 1'b0;
      for (int k = 0; k < 400; k++) begin
         load     = ($urandom_range(0, 99) < 12);
         load_val = 4'($urandom);
         en       = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) dir = ~dir;
         if (!load && !en && ($urandom_range(0, 2) == 0)) mode = ~mode;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
